// File: rtl/pfir_coef_loader.sv
// Purpose : serialises host coefficient records into 9-bit FIR programming writes, framed by
//           the FIR reset burst, address-pointer resets, a null terminator and a settle gap.
// Latency : record accepted in WAIT -> first pdata word on the next cycle, 4 words back to back.
// Backpressure: crdy is high only in WAIT; one record per 5 cycles with cv held high.
//
// Ports:
//   clk, mrst            clock, synchronous active-high reset
//   start                begin a load session (only honoured in IDLE)
//   cv/crdy              record handshake; cw/coef/cidx are the record fields
//   fin                  host "no more records" level, looked at in WAIT when cv=0
//   frst                 reset to the FIR engine
//   pdata/pwr/prst       FIR programming port
//   busy/cfg_done/nwr    session status, end-of-session pulse, accepted-record count

module pfir_coef_loader #(
  parameter int FRST_CYC   = 16,
  parameter int SETTLE_CYC = 8
) (
  input  logic        clk,
  input  logic        mrst,
  input  logic        start,
  input  logic        cv,
  output logic        crdy,
  input  logic        cw,
  input  logic [24:0] coef,
  input  logic [9:0]  cidx,
  input  logic        fin,
  output logic        frst,
  output logic [8:0]  pdata,
  output logic        pwr,
  output logic        prst,
  output logic        busy,
  output logic        cfg_done,
  output logic [10:0] nwr
);

  typedef enum logic [3:0] {
    S_IDLE, S_FRST, S_GAP0, S_PRST1, S_GAP1, S_WAIT,
    S_SER, S_TERM, S_PRST2, S_GAP2, S_SETTLE, S_DONE
  } state_t;

  localparam logic [15:0] FRST_LD   = 16'(FRST_CYC - 1);
  localparam logic [15:0] SETTLE_LD = 16'(SETTLE_CYC - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  wcnt_q, wcnt_d;
  // Words 1..3 still to be sent, lowest 9 bits next. Record packed as {cw, coef, cidx}
  // makes every programming word a plain 9-bit slice.
  logic [26:0] sreg_q, sreg_d;
  logic [8:0]  pdata_q, pdata_d;
  logic [10:0] nwr_q, nwr_d;
  logic        frst_q, frst_d;
  logic        pwr_q, pwr_d;
  logic        prst_q, prst_d;
  logic        crdy_q, crdy_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    sreg_d  = sreg_q;
    nwr_d   = nwr_q;
    pdata_d = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FRST;
          cnt_d   = FRST_LD;
          nwr_d   = '0;
        end
      end
      S_FRST: begin
        if (cnt_q == '0) state_d = S_GAP0;
        else             cnt_d   = cnt_q - 16'd1;
      end
      S_GAP0:  state_d = S_PRST1;
      S_PRST1: state_d = S_GAP1;
      S_GAP1:  state_d = S_WAIT;
      S_WAIT: begin
        // A valid record wins over fin; the terminator waits for a WAIT cycle with cv=0.
        if (cv) begin
          state_d = S_SER;
          wcnt_d  = '0;
          pdata_d = cidx[8:0];
          sreg_d  = {cw, coef, cidx[9]};
          if (nwr_q != 11'h7FF) nwr_d = nwr_q + 11'd1;
        end else if (fin) begin
          state_d = S_TERM;
          wcnt_d  = '0;
          sreg_d  = '0;
        end
      end
      S_SER, S_TERM: begin
        if (wcnt_q == 2'd3) begin
          state_d = (state_q == S_SER) ? S_WAIT : S_PRST2;
        end else begin
          wcnt_d  = wcnt_q + 2'd1;
          pdata_d = sreg_q[8:0];
          sreg_d  = {9'd0, sreg_q[26:9]};
        end
      end
      S_PRST2: state_d = S_GAP2;
      S_GAP2: begin
        state_d = S_SETTLE;
        cnt_d   = SETTLE_LD;
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 16'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with the registered state.
    frst_d = (state_d == S_FRST);
    pwr_d  = (state_d == S_SER) || (state_d == S_TERM);
    prst_d = (state_d == S_PRST1) || (state_d == S_PRST2);
    crdy_d = (state_d == S_WAIT);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (mrst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      sreg_q  <= '0;
      pdata_q <= '0;
      nwr_q   <= '0;
      frst_q  <= 1'b0;
      pwr_q   <= 1'b0;
      prst_q  <= 1'b0;
      crdy_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      sreg_q  <= sreg_d;
      pdata_q <= pdata_d;
      nwr_q   <= nwr_d;
      frst_q  <= frst_d;
      pwr_q   <= pwr_d;
      prst_q  <= prst_d;
      crdy_q  <= crdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign crdy     = crdy_q;
  assign frst     = frst_q;
  assign pdata    = pdata_q;
  assign pwr      = pwr_q;
  assign prst     = prst_q;
  assign busy     = busy_q;
  assign cfg_done = done_q;
  assign nwr      = nwr_q;

endmodule

// File: tb/tb_pfir_coef_loader.sv
// Purpose : self-checking bench for pfir_coef_loader (encoding table, directed corners,
//           random sessions against a token-stream reference model).
// Latency : n/a.
// Backpressure: host driver holds cv until it sees crdy.

module tb_pfir_coef_loader;

  localparam int FRST_CYC   = 16;
  localparam int SETTLE_CYC = 8;

  logic        clk = 1'b0;
  logic        mrst, start, cv, cw, fin;
  logic [24:0] coef;
  logic [9:0]  cidx;
  logic        crdy, frst, pwr, prst, busy, cfg_done;
  logic [8:0]  pdata;
  logic [10:0] nwr;

  always #5 clk = ~clk;

  pfir_coef_loader #(.FRST_CYC(FRST_CYC), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk(clk), .mrst(mrst), .start(start), .cv(cv), .crdy(crdy), .cw(cw),
    .coef(coef), .cidx(cidx), .fin(fin), .frst(frst), .pdata(pdata), .pwr(pwr),
    .prst(prst), .busy(busy), .cfg_done(cfg_done), .nwr(nwr)
  );

  typedef struct {
    logic        cw;
    logic [24:0] coef;
    logic [9:0]  cidx;
  } rec_t;

  typedef struct {
    logic        cw;
    logic [24:0] coef;
    logic [9:0]  cidx;
    logic [8:0]  w0, w1, w2, w3;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  rec_t sess_q[$];
  int   obs_q[$];      // -1 marks a prst cycle, otherwise a pdata word seen with pwr=1
  int   prst_cyc[$];
  int   acc_cyc[$];
  int   frst_cnt = 0, first_frst = 0, last_frst = 0;
  int   done_cnt = 0, done_cyc = 0, last_pwr_cyc = 0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Every-cycle invariants plus event capture for the session checks.
  always @(negedge clk) begin
    chk("pwr_prst_exclusive", int'(pwr & prst), 0);
    if (!pwr) chk("pdata_zero_when_idle", int'(pdata), 0);
    if (pwr) begin
      obs_q.push_back(int'(pdata));
      last_pwr_cyc = cyc;
    end
    if (prst) begin
      obs_q.push_back(-1);
      prst_cyc.push_back(cyc);
    end
    if (frst) begin
      if (frst_cnt == 0) first_frst = cyc;
      last_frst = cyc;
      frst_cnt++;
    end
    if (cfg_done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_at_done", int'(busy), 1);
    end
  end

  function automatic rec_t rand_rec();
    rec_t r;
    r.cw   = 1'($urandom_range(0, 1));
    r.coef = 25'($urandom);
    r.cidx = 10'($urandom);
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_rec(input rec_t r, input bit with_fin);
    bit got;
    got  = 1'b0;
    cv   = 1'b1;
    cw   = r.cw;
    coef = r.coef;
    cidx = r.cidx;
    if (with_fin) fin = 1'b1;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      if (crdy) begin
        @(posedge clk);
        #1;
        got = 1'b1;
        acc_cyc.push_back(cyc);
      end
    end
    cv   = 1'b0;
    cw   = 1'b0;
    coef = '0;
    cidx = '0;
    if (!got) chk("accept_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_crdy"}, int'(crdy), 0);
    chk({tag, "_frst"}, int'(frst), 0);
    chk({tag, "_pdata"}, int'(pdata), 0);
    chk({tag, "_pwr"}, int'(pwr), 0);
    chk({tag, "_prst"}, int'(prst), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_cfg_done"}, int'(cfg_done), 0);
    chk({tag, "_nwr"}, int'(nwr), 0);
  endtask

  // Runs one session with the records in sess_q. fin_at = index of the record sent together
  // with fin (-1: fin raised only after the last record).
  task automatic run_session(input int gap_max, input int fin_at, input bit start_mid);
    int   exp_q[$];
    int   n, exp_nwr;
    bit   seen;
    rec_t r;
    n = sess_q.size();
    seen = 1'b0;
    obs_q.delete();
    prst_cyc.delete();
    acc_cyc.delete();
    frst_cnt = 0;
    done_cnt = 0;
    done_cyc = 0;
    last_pwr_cyc = 0;

    start = 1'b1;
    idle(1);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gap_max > 0) idle($urandom_range(0, gap_max));
      if (start_mid && i == n / 2) start = 1'b1;
      send_rec(sess_q[i], i == fin_at);
      start = 1'b0;
    end
    fin = 1'b1;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(negedge clk);
      if (cfg_done) seen = 1'b1;
    end
    if (!seen) chk("cfg_done_timeout", 0, 1);
    idle(1);
    fin = 1'b0;
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
    chk("cfg_done_single_pulse", int'(cfg_done), 0);
    chk("cfg_done_count", done_cnt, 1);

    // Reference: pointer reset, four words per record, four-word null terminator, pointer reset.
    exp_q.push_back(-1);
    for (int i = 0; i < n; i++) begin
      r = sess_q[i];
      exp_q.push_back(int'(r.cidx[8:0]));
      exp_q.push_back(int'({r.coef[7:0], r.cidx[9]}));
      exp_q.push_back(int'(r.coef[16:8]));
      exp_q.push_back(int'({r.cw, r.coef[24:17]}));
    end
    repeat (4) exp_q.push_back(0);
    exp_q.push_back(-1);

    chk("token_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("token%0d", i), obs_q[i], exp_q[i]);
    exp_nwr = (n > 2047) ? 2047 : n;
    chk("nwr_after_done", int'(nwr), exp_nwr);
    chk("frst_cycles", frst_cnt, FRST_CYC);
    chk("frst_contiguous", last_frst - first_frst, FRST_CYC - 1);
    chk("prst_pulses", prst_cyc.size(), 2);
    if (prst_cyc.size() == 2) begin
      chk("frst_to_prst1", prst_cyc[0] - first_frst, FRST_CYC + 1);
      chk("term_to_prst2", prst_cyc[1] - last_pwr_cyc, 1);
      chk("prst2_to_done", done_cyc - prst_cyc[1], SETTLE_CYC + 2);
    end
    if (gap_max == 0)
      for (int i = 1; i < acc_cyc.size(); i++)
        chk("accept_interval", acc_cyc[i] - acc_cyc[i-1], 5);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt[5];
    rec_t r;
    int   n, fa;

    vt[0] = '{cw: 1'b1, coef: 25'd8388594, cidx: 10'd19,
              w0: 9'h013, w1: 9'h1E4, w2: 9'h1FF, w3: 9'h13F};
    vt[1] = '{cw: 1'b0, coef: -25'd104, cidx: 10'd1,
              w0: 9'h001, w1: 9'h130, w2: 9'h1FF, w3: 9'h0FF};
    vt[2] = '{cw: 1'b1, coef: 25'd0, cidx: 10'd512,
              w0: 9'h000, w1: 9'h001, w2: 9'h000, w3: 9'h100};
    vt[3] = '{cw: 1'b0, coef: 25'h1FFFFFF, cidx: 10'd1023,
              w0: 9'h1FF, w1: 9'h1FF, w2: 9'h1FF, w3: 9'h0FF};
    vt[4] = '{cw: 1'b1, coef: 25'h0AAAAAA, cidx: 10'h155,
              w0: 9'h155, w1: 9'h154, w2: 9'h0AA, w3: 9'h155};

    mrst = 1'b1; start = 1'b0; cv = 1'b0; cw = 1'b0; fin = 1'b0;
    coef = '0; cidx = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs("reset");
    idle(1);
    mrst = 1'b0;
    idle(2);

    // Encoding table: one record per session, words compared to the table entries.
    for (int v = 0; v < 5; v++) begin
      sess_q.delete();
      r.cw = vt[v].cw; r.coef = vt[v].coef; r.cidx = vt[v].cidx;
      sess_q.push_back(r);
      run_session(0, -1, 1'b0);
      if (obs_q.size() >= 5) begin
        chk($sformatf("vec%0d_w0", v), obs_q[1], int'(vt[v].w0));
        chk($sformatf("vec%0d_w1", v), obs_q[2], int'(vt[v].w1));
        chk($sformatf("vec%0d_w2", v), obs_q[3], int'(vt[v].w2));
        chk($sformatf("vec%0d_w3", v), obs_q[4], int'(vt[v].w3));
      end else begin
        chk($sformatf("vec%0d_words_seen", v), obs_q.size(), 5);
      end
      idle(2);
    end

    // Zero-record session: terminator only.
    sess_q.delete();
    run_session(0, -1, 1'b0);
    idle(2);

    // cv and fin together on the first of three back-to-back records.
    sess_q.delete();
    repeat (3) sess_q.push_back(rand_rec());
    run_session(0, 0, 1'b0);
    idle(2);

    // 37 back-to-back records with a start pulse in the middle.
    sess_q.delete();
    repeat (37) sess_q.push_back(rand_rec());
    run_session(0, -1, 1'b1);
    idle(2);

    // Random sessions with random host gaps.
    for (int s = 0; s < 8; s++) begin
      sess_q.delete();
      n = $urandom_range(0, 6);
      repeat (n) sess_q.push_back(rand_rec());
      fa = (n > 0 && $urandom_range(0, 1) == 1) ? n - 1 : -1;
      run_session($urandom_range(0, 3), fa, 1'b0);
      idle($urandom_range(1, 4));
    end

    // Counter saturation.
    sess_q.delete();
    repeat (2050) sess_q.push_back(rand_rec());
    run_session(0, -1, 1'b0);
    idle(2);

    // Reset during serialisation, right after word 1.
    r = rand_rec();
    start = 1'b1;
    idle(1);
    start = 1'b0;
    send_rec(r, 1'b0);
    idle(1);
    mrst = 1'b1;
    idle(1);
    mrst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midser_reset");
    idle(2);
    sess_q.delete();
    sess_q.push_back(rand_rec());
    run_session(0, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
